el2_lsu_dccm_arb: RTL and testbench

Single-port access arbiter for the DCCM. Shares the DCCM read/write port between the LSU pipe (primary) and the DMA slave path (secondary), and drives the DCCM memory block's enable, address and write-data inputs. Routes the 1-cycle-latency read data back to the requester that issued the read. A saturating starvation counter bounds DMA latency. A one-entry buffer absorbs DMA read-response backpressure.

---
 rtl/el2_lsu_dccm_arb_if.sv | 58 +++++
 rtl/el2_lsu_dccm_arb.sv | 88 ++++++++
 tb/tb_el2_lsu_dccm_arb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/el2_lsu_dccm_arb_if.sv
// el2_lsu_dccm_arb_if: LSU, DMA and DCCM-port signal bundle for the DCCM arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface el2_lsu_dccm_arb_if #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DMA_TAG_W        = 3
);
    logic                        lsu_req_valid;
    logic                        lsu_req_ready;
    logic                        lsu_req_wr;
    logic [DCCM_BITS-1:0]        lsu_addr_lo;
    logic [DCCM_BITS-1:0]        lsu_addr_hi;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_lo;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_hi;
    logic                        lsu_rsp_valid;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_rsp_data_lo;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_rsp_data_hi;
    logic                        dma_req_valid;
    logic                        dma_req_ready;
    logic                        dma_req_wr;
    logic [DCCM_BITS-1:0]        dma_addr;
    logic [DCCM_FDATA_WIDTH-1:0] dma_wdata;
    logic [DMA_TAG_W-1:0]        dma_req_tag;
    logic                        dma_rsp_valid;
    logic                        dma_rsp_ready;
    logic [DCCM_FDATA_WIDTH-1:0] dma_rsp_data;
    logic [DMA_TAG_W-1:0]        dma_rsp_tag;
    logic                        dccm_wren;
    logic                        dccm_rden;
    logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
    logic [DCCM_BITS-1:0]        dccm_wr_addr_hi;
    logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi;

    modport slave (
        input  lsu_req_valid, lsu_req_wr, lsu_addr_lo, lsu_addr_hi, lsu_wdata_lo, lsu_wdata_hi,
        input  dma_req_valid, dma_req_wr, dma_addr, dma_wdata, dma_req_tag, dma_rsp_ready,
        input  dccm_rd_data_lo, dccm_rd_data_hi,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data_lo, lsu_rsp_data_hi,
        output dma_req_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_tag,
        output dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
        output dccm_wr_data_lo, dccm_wr_data_hi
    );

    modport master (
        output lsu_req_valid, lsu_req_wr, lsu_addr_lo, lsu_addr_hi, lsu_wdata_lo, lsu_wdata_hi,
        output dma_req_valid, dma_req_wr, dma_addr, dma_wdata, dma_req_tag, dma_rsp_ready,
        output dccm_rd_data_lo, dccm_rd_data_hi,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data_lo, lsu_rsp_data_hi,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_tag,
        input  dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
        input  dccm_wr_data_lo, dccm_wr_data_hi
    );
endinterface

// File: rtl/el2_lsu_dccm_arb.sv
// el2_lsu_dccm_arb: shares the DCCM port between LSU (primary) and DMA (secondary),
// with a starvation bound for DMA and a one-entry DMA read-response buffer.
module el2_lsu_dccm_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DMA_STARVE_MAX   = 7,
    parameter int DMA_TAG_W        = 3
) (
    input logic clk,
    input logic rst_l,
    el2_lsu_dccm_arb_if.slave bus
);
    localparam int SW = $clog2(DMA_STARVE_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_DMA} owner_t;

    owner_t                      rd_owner_q;
    logic [SW-1:0]               starve_cnt;
    logic [DMA_TAG_W-1:0]        tag_q;
    logic                        buf_valid;
    logic [DCCM_FDATA_WIDTH-1:0] buf_data;
    logic [DMA_TAG_W-1:0]        buf_tag;

    logic dma_elig, force_dma, starve_max, gnt_lsu, gnt_dma;
    logic lsu_wr, lsu_rd, dma_wr, dma_rd;
    logic [DCCM_BITS-1:0] wr_lo, wr_hi, rd_lo, rd_hi;

    // A DMA read is only eligible when its response is guaranteed a free buffer slot.
    always_comb begin
        starve_max = starve_cnt == SW'(DMA_STARVE_MAX);
        dma_elig   = bus.dma_req_valid &
                     (bus.dma_req_wr | ((rd_owner_q != OWN_DMA) & (!buf_valid | bus.dma_rsp_ready)));
        force_dma  = dma_elig & starve_max;
        gnt_dma    = force_dma | (!bus.lsu_req_valid & dma_elig);
        gnt_lsu    = !force_dma & bus.lsu_req_valid;
        lsu_wr     = gnt_lsu & bus.lsu_req_wr;
        lsu_rd     = gnt_lsu & !bus.lsu_req_wr;
        dma_wr     = gnt_dma & bus.dma_req_wr;
        dma_rd     = gnt_dma & !bus.dma_req_wr;
        wr_lo      = lsu_wr ? bus.lsu_addr_lo : dma_wr ? bus.dma_addr : '0;
        wr_hi      = lsu_wr ? bus.lsu_addr_hi : dma_wr ? bus.dma_addr : '0;
        rd_lo      = lsu_rd ? bus.lsu_addr_lo : dma_rd ? bus.dma_addr : '0;
        rd_hi      = lsu_rd ? bus.lsu_addr_hi : dma_rd ? bus.dma_addr : '0;
    end

    assign bus.lsu_req_ready   = !force_dma;
    assign bus.dma_req_ready   = gnt_dma;
    assign bus.dccm_wren       = lsu_wr | dma_wr;
    assign bus.dccm_rden       = lsu_rd | dma_rd;
    assign bus.dccm_wr_addr_lo = wr_lo;
    assign bus.dccm_wr_addr_hi = wr_hi;
    assign bus.dccm_rd_addr_lo = rd_lo;
    assign bus.dccm_rd_addr_hi = rd_hi;
    assign bus.dccm_wr_data_lo = lsu_wr ? bus.lsu_wdata_lo : dma_wr ? bus.dma_wdata : '0;
    assign bus.dccm_wr_data_hi = lsu_wr ? bus.lsu_wdata_hi : dma_wr ? bus.dma_wdata : '0;

    assign bus.lsu_rsp_valid   = rd_owner_q == OWN_LSU;
    assign bus.lsu_rsp_data_lo = bus.lsu_rsp_valid ? bus.dccm_rd_data_lo : '0;
    assign bus.lsu_rsp_data_hi = bus.lsu_rsp_valid ? bus.dccm_rd_data_hi : '0;
    assign bus.dma_rsp_valid   = buf_valid;
    assign bus.dma_rsp_data    = buf_data;
    assign bus.dma_rsp_tag     = buf_tag;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            starve_cnt <= '0;
            rd_owner_q <= OWN_NONE;
            tag_q      <= '0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            buf_tag    <= '0;
        end else begin
            starve_cnt <= (!bus.dma_req_valid | gnt_dma) ? '0 :
                          (dma_elig & !starve_max) ? starve_cnt + SW'(1) : starve_cnt;
            rd_owner_q <= lsu_rd ? OWN_LSU : dma_rd ? OWN_DMA : OWN_NONE;
            if (dma_rd)
                tag_q <= bus.dma_req_tag;
            // A fill takes priority over a simultaneous drain.
            if (rd_owner_q == OWN_DMA) begin
                buf_valid <= 1'b1;
                buf_data  <= bus.dccm_rd_data_lo;
                buf_tag   <= tag_q;
            end else if (buf_valid & bus.dma_rsp_ready) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_el2_lsu_dccm_arb.sv
// tb_el2_lsu_dccm_arb: directed and random checks of the DCCM arbiter against a
// transaction-level model (pending-read queue, starvation wait count, address-hash memory).
module tb_el2_lsu_dccm_arb;
    localparam int DB = 16, DW = 39, TW = 3, MAX = 7;

    logic clk = 1'b0, rst_l = 1'b0;
    always #5 clk = ~clk;

    el2_lsu_dccm_arb_if #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(DW), .DMA_TAG_W(TW)) bus();
    el2_lsu_dccm_arb #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(DW), .DMA_STARVE_MAX(MAX), .DMA_TAG_W(TW))
        dut (.clk(clk), .rst_l(rst_l), .bus(bus));

    typedef struct { int due; logic [TW-1:0] tag; logic [DB-1:0] addr; } rd_t;
    rd_t q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, wt = 0, n_dhs = 0;
    logic lp = 1'b0, p_rden = 1'b0;
    logic [DB-1:0] lp_lo, lp_hi, p_lo, p_hi;
    logic o_lrdy, o_drdy, o_rden, o_lv, o_dv;
    logic [DB-1:0] o_rdlo;
    logic [DW-1:0] o_llo;
    logic [TW-1:0] o_dtag;
    int o_cnt;

    // The memory returns a fixed hash of the address, so routing errors show up as data errors.
    function automatic logic [DW-1:0] mem(input logic [DB-1:0] a);
        return {a[6:0] ^ 7'h5a, a, a ^ 16'hbeef};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.lsu_req_valid = 0; bus.lsu_req_wr = 0; bus.lsu_addr_lo = '0; bus.lsu_addr_hi = '0;
        bus.lsu_wdata_lo = '0; bus.lsu_wdata_hi = '0;
        bus.dma_req_valid = 0; bus.dma_req_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dma_req_tag = '0; bus.dma_rsp_ready = 0;
        bus.dccm_rd_data_lo = '0; bus.dccm_rd_data_hi = '0;
    endtask

    task automatic step();
        logic bv, infl, el, frc, gd, gl, lw, lr, dw, dr;
        bus.dccm_rd_data_lo = p_rden ? mem(p_lo) : DW'({$urandom, $urandom});
        bus.dccm_rd_data_hi = p_rden ? mem(p_hi) : DW'({$urandom, $urandom});
        bv   = q.size() > 0 && q[0].due <= cyc;
        infl = q.size() > 0 && q[q.size()-1].due == cyc + 1;
        el   = bus.dma_req_valid && (bus.dma_req_wr || (!infl && (!bv || bus.dma_rsp_ready)));
        frc  = el && wt == MAX;
        gd   = frc || (!bus.lsu_req_valid && el);
        gl   = !frc && bus.lsu_req_valid;
        lw = gl && bus.lsu_req_wr; lr = gl && !bus.lsu_req_wr;
        dw = gd && bus.dma_req_wr; dr = gd && !bus.dma_req_wr;
        @(negedge clk);
        chk("lsu_req_ready", bus.lsu_req_ready, !frc);
        chk("dma_req_ready", bus.dma_req_ready, gd);
        chk("dccm_wren", bus.dccm_wren, lw || dw);
        chk("dccm_rden", bus.dccm_rden, lr || dr);
        chk("wren_rden_excl", bus.dccm_wren && bus.dccm_rden, 0);
        chk("wr_addr_lo", bus.dccm_wr_addr_lo, lw ? bus.lsu_addr_lo : dw ? bus.dma_addr : '0);
        chk("wr_addr_hi", bus.dccm_wr_addr_hi, lw ? bus.lsu_addr_hi : dw ? bus.dma_addr : '0);
        chk("rd_addr_lo", bus.dccm_rd_addr_lo, lr ? bus.lsu_addr_lo : dr ? bus.dma_addr : '0);
        chk("rd_addr_hi", bus.dccm_rd_addr_hi, lr ? bus.lsu_addr_hi : dr ? bus.dma_addr : '0);
        chk("wr_data_lo", bus.dccm_wr_data_lo, lw ? bus.lsu_wdata_lo : dw ? bus.dma_wdata : '0);
        chk("wr_data_hi", bus.dccm_wr_data_hi, lw ? bus.lsu_wdata_hi : dw ? bus.dma_wdata : '0);
        chk("lsu_rsp_valid", bus.lsu_rsp_valid, lp);
        if (lp) begin
            chk("lsu_rsp_data_lo", bus.lsu_rsp_data_lo, mem(lp_lo));
            chk("lsu_rsp_data_hi", bus.lsu_rsp_data_hi, mem(lp_hi));
        end
        chk("dma_rsp_valid", bus.dma_rsp_valid, bv);
        if (bv) begin
            chk("dma_rsp_tag", bus.dma_rsp_tag, q[0].tag);
            chk("dma_rsp_data", bus.dma_rsp_data, mem(q[0].addr));
        end
        o_lrdy = bus.lsu_req_ready; o_drdy = bus.dma_req_ready; o_rden = bus.dccm_rden;
        o_rdlo = bus.dccm_rd_addr_lo; o_lv = bus.lsu_rsp_valid; o_llo = bus.lsu_rsp_data_lo;
        o_dv = bus.dma_rsp_valid; o_dtag = bus.dma_rsp_tag; o_cnt = int'(dut.starve_cnt);
        if (bus.dma_rsp_valid && bus.dma_rsp_ready) n_dhs++;
        if (bv && bus.dma_rsp_ready) void'(q.pop_front());
        if (dr) q.push_back('{cyc + 2, bus.dma_req_tag, bus.dma_addr});
        lp = lr; lp_lo = bus.lsu_addr_lo; lp_hi = bus.lsu_addr_hi;
        wt = (!bus.dma_req_valid || gd) ? 0 : el ? (wt < MAX ? wt + 1 : wt) : wt;
        p_rden = bus.dccm_rden; p_lo = bus.dccm_rd_addr_lo; p_hi = bus.dccm_rd_addr_hi;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_l = 0;
        #2;
        chk("rst_lsu_req_ready", bus.lsu_req_ready, 1);
        chk("rst_dma_req_ready", bus.dma_req_ready, 0);
        chk("rst_wren", bus.dccm_wren, 0);
        chk("rst_rden", bus.dccm_rden, 0);
        chk("rst_addrs", {bus.dccm_wr_addr_lo, bus.dccm_wr_addr_hi, bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, 0);
        chk("rst_wdata", bus.dccm_wr_data_lo | bus.dccm_wr_data_hi, 0);
        chk("rst_lsu_rsp", {bus.lsu_rsp_valid, bus.lsu_rsp_data_lo | bus.lsu_rsp_data_hi}, 0);
        chk("rst_dma_rsp", {bus.dma_rsp_valid, bus.dma_rsp_tag, bus.dma_rsp_data}, 0);
        chk("rst_starve_cnt", dut.starve_cnt, 0);
        q.delete(); wt = 0; lp = 0; p_rden = 0;
        @(negedge clk);
        rst_l = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        // LSU read at 0x0104: address out in the request cycle, data back the next cycle.
        bus.lsu_req_valid = 1; bus.lsu_addr_lo = 16'h0104; bus.lsu_addr_hi = 16'h0108;
        step();
        chk("lsu_rd_rden", o_rden, 1);
        chk("lsu_rd_addr", o_rdlo, 16'h0104);
        idle();
        step();
        chk("lsu_rd_rsp_valid", o_lv, 1);
        chk("lsu_rd_rsp_data", o_llo, mem(16'h0104));
        // Continuous LSU and DMA writes: DMA forced in cycle MAX+1.
        for (int i = 1; i <= MAX + 2; i++) begin
            bus.lsu_req_valid = 1; bus.lsu_req_wr = 1; bus.lsu_addr_lo = DB'($urandom);
            bus.lsu_addr_hi = bus.lsu_addr_lo; bus.lsu_wdata_lo = DW'({$urandom, $urandom});
            bus.dma_req_valid = 1; bus.dma_req_wr = 1; bus.dma_addr = DB'($urandom);
            bus.dma_wdata = DW'({$urandom, $urandom});
            step();
            chk("starve_dma_gnt", o_drdy, i == MAX + 1);
            chk("starve_lsu_rdy", o_lrdy, i != MAX + 1);
            if (i == MAX + 2) chk("starve_cnt_cleared", o_cnt, 0);
        end
        idle();
        step();
        // DMA read under response backpressure.
        bus.dma_req_valid = 1; bus.dma_req_tag = 3'd5; bus.dma_addr = 16'h0200;
        step();
        chk("bp_first_gnt", o_drdy, 1);
        bus.dma_req_tag = 3'd6; bus.dma_addr = 16'h0300;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("bp_second_held", o_drdy, 0);
            if (k >= 3) begin
                chk("bp_rsp_valid", o_dv, 1);
                chk("bp_rsp_tag", o_dtag, 5);
            end
        end
        bus.dma_rsp_ready = 1;
        step();
        chk("bp_second_gnt", o_drdy, 1);
        chk("bp_rsp_tag_drain", o_dtag, 5);
        idle(); bus.dma_rsp_ready = 1;
        step();
        step();
        chk("bp_second_rsp", o_dv, 1);
        chk("bp_second_tag", o_dtag, 6);
        step();
        step();
        // Back-to-back DMA reads: one read per two cycles, one response each.
        n_dhs = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.dma_req_valid = 1; bus.dma_req_wr = 0; bus.dma_req_tag = TW'(i);
            bus.dma_addr = DB'($urandom); bus.dma_rsp_ready = 1;
            step();
            chk("b2b_gnt", o_drdy, i % 2 == 1);
        end
        idle(); bus.dma_rsp_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("b2b_rsp_count", n_dhs, 3);
        // Reset while a DMA read is in flight.
        idle(); bus.dma_req_valid = 1; bus.dma_addr = 16'h0440; bus.dma_req_tag = 3'd2;
        step();
        chk("rst_rd_gnt", o_drdy, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_rsp", o_dv, 0);
        end
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            bus.lsu_req_valid = $urandom_range(0, 9) < 6;
            bus.lsu_req_wr    = 1'($urandom_range(0, 1));
            bus.lsu_addr_lo   = DB'($urandom);
            bus.lsu_addr_hi   = $urandom_range(0, 3) == 0 ? bus.lsu_addr_lo + 16'd4 : bus.lsu_addr_lo;
            bus.lsu_wdata_lo  = DW'({$urandom, $urandom});
            bus.lsu_wdata_hi  = DW'({$urandom, $urandom});
            bus.dma_req_valid = $urandom_range(0, 9) < 5;
            bus.dma_req_wr    = 1'($urandom_range(0, 1));
            bus.dma_addr      = DB'($urandom);
            bus.dma_wdata     = DW'({$urandom, $urandom});
            bus.dma_req_tag   = TW'($urandom);
            bus.dma_rsp_ready = $urandom_range(0, 9) < 6;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
